program_loader: RTL and testbench

- Boot-time loader directly upstream of the pipelined MIPS core and its instruction ROM.
- Receives a framed byte stream over a valid/ready interface, assembles big-endian 32-bit instructions and writes them sequentially into program memory.
- Verifies an XOR checksum, then releases the core from hold.
- The core's PC fetches from the same byte addresses written here (word index × 4).

---
 rtl/program_loader.sv | 197 +++++++++++++++++++
 tb/tb_program_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot-time program loader.
// Receives a framed byte stream, packs the bytes into big-endian 32-bit words,
// writes them into program memory one after another, checks the frame's XOR
// checksum and only then lets the core out of hold.
//
// Frame: LEN_HI, LEN_LO, 4*N data bytes (MSB first per word), checksum byte.
// The checksum is the XOR of every earlier byte in the frame, including both
// length bytes.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | after reset, waiting for start_i; core held
// LEN_HI | waiting for the high byte of the word count
// LEN_LO | waiting for the low byte; length is range-checked here
// DATA   | collecting the four bytes of the current word
// WRITE  | one-cycle write strobe for the assembled word
// CHECK  | waiting for the checksum byte
// DONE   | frame loaded and checksum good; core released
// ERROR  | frame rejected (length too big or bad checksum); core held
module program_loader #(
  parameter int MEMORY_DEPTH = 64,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        mem_write_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_data_o,
  output logic        cpu_hold_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(MEMORY_DEPTH);

  state_t                state;
  logic [7:0]            len_hi_q;
  logic [ADDR_WIDTH-1:0] word_count;
  logic [ADDR_WIDTH-1:0] word_index;
  logic [1:0]            byte_cnt;
  logic [31:0]           word_q;
  logic [7:0]            xor_q;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] frame_len;
  logic [ADDR_WIDTH-1:0] index_next;
  logic [31:0]           word_next;
  logic [7:0]            xor_next;

  // Handshake and next-value helpers. byte_ready_o is a registered copy of
  // "state accepts bytes", so it can be used directly as the accept qualifier.
  assign accept     = byte_valid_i && byte_ready_o;
  assign frame_len  = ADDR_WIDTH'({len_hi_q, byte_data_i});
  assign index_next = word_index + ADDR_WIDTH'(1);
  assign word_next  = {word_q[23:0], byte_data_i};
  assign xor_next   = xor_q ^ byte_data_i;

  // Loader state machine; every output is registered and is updated together
  // with the state it belongs to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      len_hi_q      <= '0;
      word_count    <= '0;
      word_index    <= '0;
      byte_cnt      <= '0;
      word_q        <= '0;
      xor_q         <= '0;
      byte_ready_o  <= 1'b0;
      mem_write_o   <= 1'b0;
      mem_address_o <= '0;
      mem_data_o    <= '0;
      cpu_hold_o    <= 1'b1;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      error_o       <= 1'b0;
    end else begin
      mem_write_o <= 1'b0;
      unique case (state)
        IDLE, DONE, ERROR: begin
          // A new frame always starts from a clean slate and re-holds the core.
          if (start_i) begin
            state        <= LEN_HI;
            len_hi_q     <= '0;
            word_count   <= '0;
            word_index   <= '0;
            byte_cnt     <= '0;
            word_q       <= '0;
            xor_q        <= '0;
            byte_ready_o <= 1'b1;
            cpu_hold_o   <= 1'b1;
            busy_o       <= 1'b1;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
          end
        end

        LEN_HI: begin
          if (accept) begin
            len_hi_q <= byte_data_i;
            xor_q    <= xor_next;
            state    <= LEN_LO;
          end
        end

        LEN_LO: begin
          if (accept) begin
            word_count <= frame_len;
            xor_q      <= xor_next;
            word_index <= '0;
            byte_cnt   <= '0;
            if (frame_len > DEPTH_LIMIT) begin
              // Rejected before any write so memory is never overrun.
              state        <= ERROR;
              byte_ready_o <= 1'b0;
              busy_o       <= 1'b0;
              error_o      <= 1'b1;
            end else if (frame_len == '0) begin
              state <= CHECK;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (accept) begin
            word_q   <= word_next;
            xor_q    <= xor_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Present the finished word during the WRITE cycle.
              state         <= WRITE;
              byte_ready_o  <= 1'b0;
              mem_write_o   <= 1'b1;
              mem_address_o <= 32'(word_index) << 2;
              mem_data_o    <= word_next;
            end
          end
        end

        WRITE: begin
          word_index   <= index_next;
          byte_cnt     <= '0;
          byte_ready_o <= 1'b1;
          if (index_next == word_count) begin
            state <= CHECK;
          end else begin
            state <= DATA;
          end
        end

        CHECK: begin
          if (accept) begin
            byte_ready_o <= 1'b0;
            busy_o       <= 1'b0;
            if (byte_data_i == xor_q) begin
              state      <= DONE;
              done_o     <= 1'b1;
              cpu_hold_o <= 1'b0;
            end else begin
              state      <= ERROR;
              error_o    <= 1'b1;
              cpu_hold_o <= 1'b1;
            end
          end
        end

        default: begin
          state        <= IDLE;
          byte_ready_o <= 1'b0;
          cpu_hold_o   <= 1'b1;
          busy_o       <= 1'b0;
          done_o       <= 1'b0;
          error_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a table of frames with fixed
// expectations, hand-written reset corner cases, then random frames checked
// against a frame-level reference model.
module tb_program_loader;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = 8'h00;
  logic        byte_ready_o;
  logic        mem_write_o;
  logic [31:0] mem_address_o;
  logic [31:0] mem_data_o;
  logic        cpu_hold_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  program_loader #(.MEMORY_DEPTH(DEPTH), .ADDR_WIDTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .byte_valid_i  (byte_valid_i),
    .byte_data_i   (byte_data_i),
    .byte_ready_o  (byte_ready_o),
    .mem_write_o   (mem_write_o),
    .mem_address_o (mem_address_o),
    .mem_data_o    (mem_data_o),
    .cpu_hold_o    (cpu_hold_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .error_o       (error_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_count = 0;
  logic prev_wr = 1'b0;
  logic [31:0] words [DEPTH];

  typedef struct {
    logic [15:0] len;
    logic [31:0] seed;
    int          chk_mode;   // 0 correct, 1 explicit chk_val, 2 corrupted
    logic [7:0]  chk_val;
    bit          gap;
    bit          exp_done;
    bit          exp_error;
    int          exp_writes;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Every strobe must be isolated to a single cycle; also counts writes.
  always @(negedge clk) begin
    if (mem_write_o) begin
      wr_count++;
      check("single_cycle_strobe", prev_wr, 1'b0);
    end
    prev_wr = mem_write_o;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill_words(input logic [31:0] seed);
    for (int i = 0; i < DEPTH; i++) words[i] = seed ^ (32'(i) * 32'h9E3779B9);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int waited;
    bit got;
    if (gap) begin
      byte_valid_i = 1'b0;
      @(posedge clk);
      #1;
    end
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    waited = 0;
    got = 1'b0;
    while (!got && waited < 64) begin
      @(negedge clk);
      if (byte_ready_o) begin
        @(posedge clk);
        #1;
        got = 1'b1;
      end else begin
        waited++;
      end
    end
    byte_valid_i = 1'b0;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: byte %h not accepted within 64 cycles", b);
    end
  endtask

  task automatic run_frame(input logic [15:0] len, input int chk_mode, input logic [7:0] chk_val,
                           input bit gap, input bit exp_done, input bit exp_error, input int exp_writes);
    logic [7:0]  x;
    logic [31:0] w;
    int          wc0;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check("start_busy", busy_o, 1'b1);
    check("start_hold", cpu_hold_o, 1'b1);
    check("start_ready", byte_ready_o, 1'b1);
    check("start_done_clr", done_o, 1'b0);
    check("start_error_clr", error_o, 1'b0);
    wc0 = wr_count;
    x = len[15:8] ^ len[7:0];
    send_byte(len[15:8], gap);
    send_byte(len[7:0], gap);
    if (int'(len) <= DEPTH) begin
      for (int i = 0; i < int'(len); i++) begin
        w = words[i];
        x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gap);
        @(negedge clk);
        check("write_strobe", mem_write_o, 1'b1);
        check("write_addr", mem_address_o, 32'(i * 4));
        check("write_data", mem_data_o, w);
      end
      case (chk_mode)
        0:       send_byte(x, gap);
        1:       send_byte(chk_val, gap);
        default: send_byte(x ^ 8'h5A, gap);
      endcase
    end
    check("end_done", done_o, exp_done);
    check("end_error", error_o, exp_error);
    check("end_hold", cpu_hold_o, !exp_done);
    check("end_busy", busy_o, 1'b0);
    check("end_ready", byte_ready_o, 1'b0);
    check("write_count", 32'(wr_count - wc0), 32'(exp_writes));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hold"}, cpu_hold_o, 1'b1);
    check({tag, "_ready"}, byte_ready_o, 1'b0);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_error"}, error_o, 1'b0);
    check({tag, "_wr"}, mem_write_o, 1'b0);
    check({tag, "_addr"}, mem_address_o, 32'h0);
    check({tag, "_data"}, mem_data_o, 32'h0);
  endtask

  initial begin
    int          wc0;
    logic [15:0] rlen;
    int          rmode;
    bit          rgap;
    bit          over;
    bit          e_done;

    //            len       seed          mode chk    gap  done err  writes
    vecs[0] = '{16'h0001, 32'h20080005, 1, 8'h2C, 1'b0, 1'b1, 1'b0, 1};
    vecs[1] = '{16'h0002, 32'h3C010000, 0, 8'h00, 1'b1, 1'b1, 1'b0, 2};
    vecs[2] = '{16'h0041, 32'h11111111, 0, 8'h00, 1'b0, 1'b0, 1'b1, 0};
    vecs[3] = '{16'h0001, 32'h20080005, 1, 8'hFF, 1'b0, 1'b0, 1'b1, 1};
    vecs[4] = '{16'h0001, 32'h20080005, 1, 8'h2C, 1'b0, 1'b1, 1'b0, 1};
    vecs[5] = '{16'h0000, 32'h00000000, 0, 8'h00, 1'b0, 1'b1, 1'b0, 0};
    vecs[6] = '{16'h0040, 32'h12345678, 0, 8'h00, 1'b0, 1'b1, 1'b0, 64};
    vecs[7] = '{16'h0003, 32'hCAFEF00D, 2, 8'h00, 1'b1, 1'b0, 1'b1, 3};
    vecs[8] = '{16'hFFFF, 32'h0BADBEEF, 0, 8'h00, 1'b0, 1'b0, 1'b1, 0};

    // Reset state, then idle with stray traffic that must be ignored.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      byte_valid_i = 1'b1;
      byte_data_i  = 8'($urandom);
      @(negedge clk);
      check("idle_ready", byte_ready_o, 1'b0);
      check("idle_hold", cpu_hold_o, 1'b1);
      check("idle_done", done_o, 1'b0);
      check("idle_error", error_o, 1'b0);
    end
    byte_valid_i = 1'b0;
    check("idle_no_writes", 32'(wr_count), 32'h0);

    foreach (vecs[v]) begin
      fill_words(vecs[v].seed);
      run_frame(vecs[v].len, vecs[v].chk_mode, vecs[v].chk_val, vecs[v].gap,
                vecs[v].exp_done, vecs[v].exp_error, vecs[v].exp_writes);
    end

    // Reset after 2 of 4 data bytes: partial word discarded, no strobe.
    fill_words(32'hA1B2C3D4);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wc0 = wr_count;
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hB2, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_no_write", 32'(wr_count - wc0), 32'h0);
    check("midreset_idle_busy", busy_o, 1'b0);
    fill_words(32'h20080005);
    run_frame(16'h0001, 1, 8'h2C, 1'b0, 1'b1, 1'b0, 1);

    // start_i and reset together from DONE: reset wins.
    start_i = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("start_vs_reset");
    start_i = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("stay_idle_busy", busy_o, 1'b0);
    check("stay_idle_ready", byte_ready_o, 1'b0);

    // Random frames against a frame-level model.
    for (int r = 0; r < 25; r++) begin
      rlen  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(65, 300)) : 16'($urandom_range(0, 8));
      rmode = ($urandom_range(0, 3) == 0) ? 2 : 0;
      rgap  = 1'($urandom_range(0, 1));
      for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
      over   = int'(rlen) > DEPTH;
      e_done = !over && (rmode == 0);
      run_frame(rlen, rmode, 8'h00, rgap, e_done, !e_done, over ? 0 : int'(rlen));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
